spi_master_multi: RTL and testbench
===================================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per frame, legal 4..32.
REQ-002 SHALL have parameter NUM_CS, default 4, number of chip selects, legal 1..8.
REQ-003 SHALL have parameter CLK_DIV, default 4, clk cycles per sclk half-period, legal 2..255.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, transfer request, sampled on posedge clk.
REQ-007 SHALL have port tx_data, input, DATA_W, frame to transmit, latched on accepted start.
REQ-008 SHALL have port cs_sel, input, $clog2(NUM_CS) (min 1), target slave, latched on accepted start.
REQ-009 SHALL have ports cpol, cpha and lsb_first, input, 1 each, mode bits, latched on accepted start.
REQ-010 SHALL have port miso, input, 1, serial data from slave.
REQ-011 SHALL have ports busy and done, output, 1 each; busy means transfer in progress, done is a one-cycle completion pulse.
REQ-012 SHALL have port rx_data, output, DATA_W, last received frame.
REQ-013 SHALL have ports sclk, output, 1, serial clock, and mosi, output, 1, serial data out.
REQ-014 SHALL have port cs_n, output, NUM_CS, active-low selects, at most one low at a time.

Function
REQ-015 SHALL use FSM states IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
REQ-016 SHALL accept start only in IDLE when cs_sel < NUM_CS; otherwise start is ignored with no state change.
REQ-017 SHALL ignore start while busy=1, including the DONE cycle, leaving latched data, mode and cs_sel unchanged.
REQ-018 SHALL, for start accepted at cycle 0, assert busy and drive cs_n[cs_sel] low at cycle 1, holding it low without glitch until DONE.
REQ-019 SHALL hold sclk at cpol whenever not in XFER.
REQ-020 SHALL toggle sclk every CLK_DIV cycles in XFER, with the first edge at cycle 1+CLK_DIV and 2*DATA_W edges in total.
REQ-021 SHALL, for cpha=0, present the first bit on mosi at cycle 1, sample miso on leading edges and shift mosi on trailing edges.
REQ-022 SHALL, for cpha=1, shift mosi on leading edges and sample miso on trailing edges.
REQ-023 SHALL transmit and receive LSB first when lsb_first=1, and MSB first otherwise.
REQ-024 SHALL enter DONE CLK_DIV cycles after the last edge, at cycle 1+CLK_DIV*(2*DATA_W+1).
REQ-025 SHALL, in DONE: drive all cs_n high, pulse done for exactly 1 cycle with busy still 1, and update rx_data in that same cycle only.
REQ-026 SHALL deassert busy the cycle after done; a start in that cycle is accepted.
REQ-027 SHALL hold rx_data stable between done pulses.
REQ-028 SHALL ignore mode and tx_data input changes during a transfer.

Reset
REQ-029 SHALL, on rst high, immediately (asynchronously) force: state IDLE, busy=0, done=0, cs_n all 1, sclk=0, mosi=0, rx_data=0, shift registers=0.
REQ-030 SHALL abort any transfer on reset mid-operation, with no done pulse and rx_data forced to 0.
REQ-031 SHALL drive sclk to the latched cpol from the first accepted start onward; the post-reset idle sclk is 0.
REQ-032 SHALL accept start on the first posedge clk after rst deasserts.

Configuration
REQ-033 SHALL, with SPI_LOOPBACK_EN defined, add input port loopback (1 bit); when loopback=1 the receive path samples internal mosi instead of miso, and cs_n stays all high during the transfer with timing unchanged.
REQ-034 SHALL, without SPI_LOOPBACK_EN, have no loopback port and always sample miso.

Verification
REQ-035 SHALL cover: defaults, mode 0, MSB first, tx_data=8'hA5, cs_sel=2, slave returns 8'h3C -> busy at cycle 1, cs_n=4'b1011, 16 sclk edges, done at cycle 69, rx_data=8'h3C, mosi bit stream 1,0,1,0,0,1,0,1.
REQ-036 SHALL cover: cpol=1, cpha=1, lsb_first=1, tx_data=8'h01 -> sclk idles 1, mosi first bit 1 then 0s, rx_data matches slave model, done at cycle 69.
REQ-037 SHALL cover: second start at cycle 10 with tx_data=8'hFF, then start asserted in the DONE cycle -> both ignored, frame still 8'hA5; start at cycle 70 accepted.
REQ-038 SHALL cover: rst pulsed at cycle 30 mid-transfer -> same-cycle busy=0, cs_n all 1, sclk=0, no done pulse, rx_data=0.
REQ-039 SHALL cover: DATA_W=16, CLK_DIV=2, NUM_CS=1, tx_data=16'hBEEF -> done at cycle 67, rx_data equals slave word.
REQ-040 SHALL cover: SPI_LOOPBACK_EN with loopback=1, tx_data=8'h5A -> rx_data=8'h5A, cs_n all 1 throughout the transfer.

Source files
------------

// File: rtl/spi_master_multi.sv
// SPI master with up to eight chip selects and per-transfer mode selection (CPOL/CPHA, bit order).
// Latency: done pulses 1 + CLK_DIV*(2*DATA_W+1) clk cycles after the cycle in which start is accepted.
// Backpressure: start is accepted only while idle with a legal cs_sel; requests made while busy are dropped.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   start                    transfer request, sampled on posedge clk
//   tx_data, cs_sel          frame and target slave, latched when start is accepted
//   cpol, cpha, lsb_first    SPI mode and bit order, latched when start is accepted
//   miso                     serial data from the selected slave
//   busy, done               transfer in progress / one-cycle completion pulse (busy still high)
//   rx_data                  last received frame, updated only in the done cycle
//   sclk, mosi, cs_n         SPI bus; at most one cs_n bit low at a time
//
// Build option: define SPI_LOOPBACK_EN to add the 'loopback' input. With loopback=1 the
// receiver samples the internal mosi instead of miso and no chip select is asserted;
// timing is unchanged. Without the macro the port does not exist and miso is always used.

module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 4,
  parameter int CLK_DIV = 4,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int DIV_W = 8;
  localparam int EDGES = 2 * DATA_W;
  localparam int EC_W  = $clog2(EDGES + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [EC_W-1:0]  LAST_EDGE  = EC_W'(EDGES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DIV_W-1:0]  div_cnt;
  logic [EC_W-1:0]   edge_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              cpha_q;
  logic              lsb_q;
  logic              lb_q;
  logic [31:0]       cs_sel_ext;
  logic              cs_ok;
  logic              accept;
  logic              tick;
  logic              last_edge;
  logic              sclk_edge;
  logic              leading;
  logic              sample_edge;
  logic              rx_bit;

  // Bit order is normalised at load time so the shifters always work MSB-first.
  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      m[i] = (sel == CS_W'(i));
    end
    return m;
  endfunction

  assign cs_sel_ext = 32'(cs_sel);
  assign cs_ok      = cs_sel_ext < 32'(NUM_CS);
  assign accept     = (state_q == IDLE) && start && cs_ok;

  // One tick every CLK_DIV cycles while the frame is in flight; each tick in
  // SETUP or XFER is one sclk edge, the tick in HOLD ends the frame.
  assign tick        = (div_cnt == '0);
  assign last_edge   = (edge_cnt == LAST_EDGE);
  assign sclk_edge   = tick && ((state_q == SETUP) || (state_q == XFER));
  assign leading     = ~edge_cnt[0];
  // cpha=0 samples on leading edges, cpha=1 on trailing edges.
  assign sample_edge = leading ^ cpha_q;

`ifdef SPI_LOOPBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_q <= 1'b0;
    end else if (accept) begin
      lb_q <= loopback;
    end
  end
`else
  assign lb_q = 1'b0;
`endif

  assign rx_bit = lb_q ? mosi : miso;
  assign mosi   = tx_sh[DATA_W-1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)            state_d = SETUP;
      SETUP:   if (tick)              state_d = XFER;
      XFER:    if (tick && last_edge) state_d = HOLD;
      HOLD:    if (tick)              state_d = DONE;
      DONE:                           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath: divider, edge counter, shifters and registered bus outputs.
  // cs_n and sclk are registered so the bus never sees decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      sclk     <= 1'b0;
      cs_n     <= '1;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
    end else begin
      if (accept) begin
        div_cnt  <= DIV_RELOAD;
        edge_cnt <= '0;
        tx_sh    <= lsb_first ? bit_rev(tx_data) : tx_data;
        rx_sh    <= '0;
        sclk     <= cpol;
        cpha_q   <= cpha;
        lsb_q    <= lsb_first;
`ifdef SPI_LOOPBACK_EN
        cs_n     <= loopback ? '1 : ~cs_decode(cs_sel);
`else
        cs_n     <= ~cs_decode(cs_sel);
`endif
      end else if ((state_q == SETUP) || (state_q == XFER) || (state_q == HOLD)) begin
        div_cnt <= tick ? DIV_RELOAD : div_cnt - DIV_W'(1);
      end

      if (sclk_edge) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + EC_W'(1);
        if (sample_edge) begin
          rx_sh <= {rx_sh[DATA_W-2:0], rx_bit};
        end else if (edge_cnt != '0) begin
          // With cpha=1 the first leading edge keeps the first bit that has
          // been on mosi since SETUP; every later shift edge advances it.
          tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
        end
      end

      if ((state_q == HOLD) && tick) begin
        rx_data <= lsb_q ? bit_rev(rx_sh) : rx_sh;
        cs_n    <= '1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
`timescale 1ns/1ps
module tb_spi_master_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, b_start;
  logic        cpol, cpha, lsb_first, miso, lb;
  logic [7:0]  tx_a;
  logic [1:0]  cs_a;
  logic [15:0] tx_b;
  logic [0:0]  cs_b;

  logic        a_busy, a_done, a_sclk, a_mosi;
  logic [7:0]  a_rx;
  logic [3:0]  a_cs_n;
  logic        b_busy, b_done, b_sclk, b_mosi;
  logic [15:0] b_rx;
  logic [0:0]  b_cs_n;

  spi_master_multi dut_a (
    .clk(clk), .rst(rst), .start(a_start), .tx_data(tx_a), .cs_sel(cs_a),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb),
`endif
    .miso(miso), .busy(a_busy), .done(a_done), .rx_data(a_rx),
    .sclk(a_sclk), .mosi(a_mosi), .cs_n(a_cs_n)
  );

  spi_master_multi #(.DATA_W(16), .NUM_CS(1), .CLK_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .tx_data(tx_b), .cs_sel(cs_b),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .miso(miso), .busy(b_busy), .done(b_done), .rx_data(b_rx),
    .sclk(b_sclk), .mosi(b_mosi), .cs_n(b_cs_n)
  );

  // View of whichever instance the current transfer targets.
  logic        sel_b;
  logic        m_busy, m_done, m_sclk, m_mosi;
  logic [31:0] m_rx;
  logic [7:0]  m_cs_n;
  always_comb begin
    m_busy = sel_b ? b_busy : a_busy;
    m_done = sel_b ? b_done : a_done;
    m_sclk = sel_b ? b_sclk : a_sclk;
    m_mosi = sel_b ? b_mosi : a_mosi;
    m_rx   = sel_b ? {16'h0, b_rx} : {24'h0, a_rx};
    m_cs_n = sel_b ? {7'h7F, b_cs_n} : {4'hF, a_cs_n};
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rx_a, last_rx_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_stream(input logic [31:0] tx, input int dw, input bit lsb);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < dw; i++) s[i] = lsb ? tx[i] : tx[dw-1-i];
    return s;
  endfunction

  function automatic int exp_done_cyc(input int dw, input int div);
    return 1 + div * (2 * dw + 1);
  endfunction

  function automatic logic [7:0] exp_cs_n(input int cs, input bit lbk);
    logic [7:0] m;
    m = 8'hFF;
    if (!lbk) m[cs] = 1'b0;
    return m;
  endfunction

  // Slave: bit index advances on the edges where the slave shifts
  // (trailing for cpha=0, leading after the first one for cpha=1).
  function automatic logic slave_bit(input logic [31:0] sw, input int dw, input bit pha,
                                     input bit lsb, input int e);
    int idx;
    idx = pha ? ((e == 0) ? 0 : (e - 1) / 2) : e / 2;
    if (idx > dw - 1) idx = dw - 1;
    return lsb ? sw[idx] : sw[dw-1-idx];
  endfunction

  // ---------------- one transfer with monitoring ----------------
  // Entered just after a negedge; returns at the negedge of the cycle after done.
  task automatic run_xfer(input bit ub, input logic [31:0] tx, input int cs,
                          input bit pol, input bit pha, input bit lsb,
                          input logic [31:0] sw, input bit lbk,
                          input int poke1, input int poke2,
                          input logic [31:0] exp_rx, input int exp_dc, input logic [7:0] exp_cs);
    int dw, cyc, dc, edges, ndone, cs_bad, idx;
    logic [31:0] stream, prev_rx, es;
    logic prev_sclk, prev_mosi;
    dw = ub ? 16 : 8;
    sel_b = ub;
    prev_rx = ub ? last_rx_b : last_rx_a;
    es = exp_stream(tx, dw, lsb);
    cpol = pol; cpha = pha; lsb_first = lsb; lb = lbk;
    if (ub) begin b_start = 1'b1; tx_b = tx[15:0]; cs_b = 1'(cs); end
    else    begin a_start = 1'b1; tx_a = tx[7:0];  cs_a = 2'(cs); end
    edges = 0;
    miso = slave_bit(sw, dw, pha, lsb, 0);
    @(posedge clk);
    cyc = 0; dc = 0; ndone = 0; cs_bad = 0; stream = '0;
    prev_sclk = 1'b0; prev_mosi = 1'b0;
    while (cyc < exp_dc + 20 && !(dc != 0 && cyc >= dc + 1)) begin
      @(negedge clk);
      cyc++;
      a_start = 1'b0; b_start = 1'b0;
      if (cyc == 1) begin
        chk("busy at cycle 1", 32'(m_busy), 32'd1);
        chk("cs_n at cycle 1", 32'(m_cs_n), 32'(exp_cs));
        chk("sclk idle at cycle 1", 32'(m_sclk), 32'(pol));
        chk("rx held before done", m_rx, prev_rx);
        if (!pha) chk("mosi first bit", 32'(m_mosi), 32'(es[0]));
      end
      if (cyc >= 2 && m_sclk !== prev_sclk) begin
        edges++;
        if ((!pha && (edges % 2 == 1)) || (pha && (edges % 2 == 0))) begin
          idx = (edges - 1) / 2;
          if (idx < 32) stream[idx] = prev_mosi;
        end
        miso = slave_bit(sw, dw, pha, lsb, edges);
      end
      if (m_done === 1'b1) begin
        ndone++;
        if (dc == 0) begin
          dc = cyc;
          chk("rx_data at done", m_rx, exp_rx);
          chk("busy during done", 32'(m_busy), 32'd1);
          chk("cs_n at done", 32'(m_cs_n), 32'hFF);
        end
      end else if (dc == 0 && m_cs_n !== exp_cs) begin
        cs_bad++;
      end
      if (cyc == poke1 || cyc == poke2) begin
        if (ub) begin b_start = 1'b1; tx_b = 16'hFFFF; cs_b = 1'b0; end
        else    begin a_start = 1'b1; tx_a = 8'hFF; cs_a = 2'(cs + 1); end
        cpol = ~pol; cpha = ~pha; lsb_first = ~lsb;
      end
      prev_sclk = m_sclk;
      prev_mosi = m_mosi;
    end
    chk("done cycle", 32'(dc), 32'(exp_dc));
    chk("sclk edge count", 32'(edges), 32'(2 * dw));
    chk("mosi bit stream", stream, es);
    chk("done pulse count", 32'(ndone), 32'd1);
    chk("cs_n glitches", 32'(cs_bad), 32'd0);
    chk("busy after done", 32'(m_busy), 32'd0);
    chk("rx stable after done", m_rx, exp_rx);
    chk("sclk idle after done", 32'(m_sclk), 32'(pol));
    if (ub) last_rx_b = exp_rx; else last_rx_a = exp_rx;
  endtask

  typedef struct {
    bit          ub;
    logic [31:0] tx;
    int          cs;
    bit          pol;
    bit          pha;
    bit          lsb;
    logic [31:0] sw;
    int          poke1;
    int          poke2;
    logic [31:0] exp_rx;
    int          exp_dc;
    logic [7:0]  exp_cs;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ub, pol, pha, lsb;
    int cs, dw, div;
    logic [31:0] tx, sw, msk;

    // Back-to-back entries: vec 2 pokes start at cycle 10 and in its done cycle;
    // vec 3 is then launched in the cycle right after done.
    vecs[0] = '{1'b0, 32'hA5,   2, 1'b0, 1'b0, 1'b0, 32'h3C,   0,  0, 32'h3C,   69, 8'hFB};
    vecs[1] = '{1'b0, 32'h01,   0, 1'b1, 1'b1, 1'b1, 32'hC6,   0,  0, 32'hC6,   69, 8'hFE};
    vecs[2] = '{1'b0, 32'hA5,   1, 1'b0, 1'b0, 1'b0, 32'h5E,  10, 69, 32'h5E,   69, 8'hFD};
    vecs[3] = '{1'b0, 32'h3C,   3, 1'b0, 1'b1, 1'b0, 32'h81,   0,  0, 32'h81,   69, 8'hF7};
    vecs[4] = '{1'b0, 32'h96,   2, 1'b1, 1'b0, 1'b1, 32'h3A,   0,  0, 32'h3A,   69, 8'hFB};
    vecs[5] = '{1'b1, 32'hBEEF, 0, 1'b0, 1'b0, 1'b0, 32'h1234, 0,  0, 32'h1234, 67, 8'hFE};
    vecs[6] = '{1'b1, 32'h8001, 0, 1'b1, 1'b1, 1'b1, 32'hF00D, 0,  0, 32'hF00D, 67, 8'hFE};

    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; miso = 1'b0; lb = 1'b0; tx_a = '0; cs_a = '0; tx_b = '0; cs_b = '0;
    sel_b = 1'b0; last_rx_a = '0; last_rx_b = '0;
    #1;
    chk("reset busy", 32'(a_busy), 32'd0);
    chk("reset done", 32'(a_done), 32'd0);
    chk("reset cs_n", 32'(a_cs_n), 32'hF);
    chk("reset sclk", 32'(a_sclk), 32'd0);
    chk("reset mosi", 32'(a_mosi), 32'd0);
    chk("reset rx_data", 32'(a_rx), 32'd0);
    chk("reset rx_data b", 32'(b_rx), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Illegal chip select on the single-select instance is ignored.
    sel_b = 1'b1; b_start = 1'b1; cs_b = 1'b1; tx_b = 16'h5555;
    @(negedge clk);
    b_start = 1'b0;
    chk("bad cs_sel ignored", 32'(b_busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("bad cs_sel cs_n", 32'(b_cs_n), 32'h1);

    foreach (vecs[i])
      run_xfer(vecs[i].ub, vecs[i].tx, vecs[i].cs, vecs[i].pol, vecs[i].pha, vecs[i].lsb,
               vecs[i].sw, 1'b0, vecs[i].poke1, vecs[i].poke2,
               vecs[i].exp_rx, vecs[i].exp_dc, vecs[i].exp_cs);

`ifdef SPI_LOOPBACK_EN
    run_xfer(1'b0, 32'h5A, 1, 1'b0, 1'b0, 1'b0, 32'h0F, 1'b1, 0, 0, 32'h5A, 69, 8'hFF);
    lb = 1'b0;
`endif

    // Randomised transfers against the model.
    for (int k = 0; k < 20; k++) begin
      ub  = 1'($urandom_range(0, 1));
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      lsb = 1'($urandom_range(0, 1));
      cs  = ub ? 0 : int'($urandom_range(0, 3));
      dw  = ub ? 16 : 8;
      div = ub ? 2 : 4;
      msk = ub ? 32'hFFFF : 32'hFF;
      tx  = $urandom & msk;
      sw  = $urandom & msk;
      run_xfer(ub, tx, cs, pol, pha, lsb, sw, 1'b0, 0, 0, sw,
               exp_done_cyc(dw, div), exp_cs_n(cs, 1'b0));
    end

    // Reset in the middle of a transfer (cpol=1 so the forced sclk=0 is visible).
    sel_b = 1'b0; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; tx_a = 8'hC3; cs_a = 2'd1;
    a_start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (c == 29) chk("busy before abort", 32'(a_busy), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(a_busy), 32'd0);
    chk("abort done", 32'(a_done), 32'd0);
    chk("abort cs_n", 32'(a_cs_n), 32'hF);
    chk("abort sclk", 32'(a_sclk), 32'd0);
    chk("abort mosi", 32'(a_mosi), 32'd0);
    chk("abort rx_data", 32'(a_rx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_rx_a = '0; last_rx_b = '0;
    begin
      int nd, nb;
      nd = 0; nb = 0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (a_done !== 1'b0) nd++;
        if (a_busy !== 1'b0) nb++;
      end
      chk("no done after abort", 32'(nd), 32'd0);
      chk("idle after abort", 32'(nb), 32'd0);
      chk("rx zero after abort", 32'(a_rx), 32'd0);
    end

    // Start on the first posedge after reset release.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_xfer(1'b0, 32'h6B, 3, 1'b0, 1'b1, 1'b1, 32'hD2, 1'b0, 0, 0, 32'hD2, 69, 8'hF7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
